dma_controller: RTL and testbench

- Bus-master end of the CPU DMA handshake. Accepts the CPU's one-bit `cmd` start request and raises BR.
- After BG is granted, takes the shared data-memory port and copies a fixed block from the external device into data memory as 64-bit bursts.
- Releases the bus and pulses `dma_end` back to the CPU as the completion interrupt.
- Sits beside the CPU and cache on the data-memory bus, which it drives through tri-states.

---
 rtl/dma_controller_pkg.sv | 19 +
 rtl/dma_bus_driver.sv | 30 +++
 rtl/dma_controller.sv | 129 ++++++++++++
 tb/tb_dma_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_controller_pkg.sv
// Shared constants and state encoding for the DMA controller.
// Holds the default bus geometry, the default transfer block and the FSM state type
// used by the controller and its bus driver.
package dma_controller_pkg;

  localparam int unsigned DMA_WORD_SIZE   = 16;
  localparam int unsigned DMA_FETCH_SIZE  = 64;
  localparam logic [15:0] DMA_BASE_ADDR   = 16'h01F4;
  localparam int unsigned DMA_TOTAL_WORDS = 12;
  localparam int unsigned DMA_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StXfer = 2'd2,
    StDone = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_bus_driver.sv
// Tri-state driver for the shared data-memory port.
// Ports:
//   own_i       - controller currently owns the bus
//   addr_i      - burst base address to present
//   data_i      - burst data to present
//   d_read_o    - read strobe: 0 while owning, else Z
//   d_write_o   - write strobe: 1 while owning, else Z
//   d_address_o - address while owning, else Z
//   d_data_io   - data while owning, else Z (never read here)
module dma_bus_driver
  import dma_controller_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DMA_WORD_SIZE,
  parameter int unsigned FETCH_SIZE = DMA_FETCH_SIZE
) (
  input  logic                  own_i,
  input  logic [WORD_SIZE-1:0]  addr_i,
  input  logic [FETCH_SIZE-1:0] data_i,
  output logic                  d_read_o,
  output logic                  d_write_o,
  output logic [WORD_SIZE-1:0]  d_address_o,
  inout  logic [FETCH_SIZE-1:0] d_data_io
);

  assign d_read_o    = own_i ? 1'b0   : 1'bz;
  assign d_write_o   = own_i ? 1'b1   : 1'bz;
  assign d_address_o = own_i ? addr_i : {WORD_SIZE{1'bz}};
  assign d_data_io   = own_i ? data_i : {FETCH_SIZE{1'bz}};

endmodule

// File: rtl/dma_controller.sv
// DMA bus master: on a CPU start request it raises BR, waits for BG, copies a fixed
// block from the external device into data memory as multi-word bursts, then releases
// the bus and pulses dma_end.
// Ports:
//   Clk, Reset_N - clock, asynchronous active-low reset
//   cmd          - start request (level-sampled in IDLE only)
//   BG / BR      - bus grant in / bus request out (registered)
//   dma_end      - one-cycle completion pulse (registered)
//   d_readM, d_writeM, d_address, d_data - data-memory port, Z unless owning the bus
//   dev_offset   - word offset requested from the device
//   dev_data     - device data for dev_offset (combinational from the device)
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int unsigned          WORD_SIZE   = DMA_WORD_SIZE,
  parameter int unsigned          FETCH_SIZE  = DMA_FETCH_SIZE,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR   = WORD_SIZE'(DMA_BASE_ADDR),
  parameter int unsigned          TOTAL_WORDS = DMA_TOTAL_WORDS,
  parameter int unsigned          MEM_LATENCY = DMA_MEM_LATENCY
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  cmd,
  input  logic                  BG,
  output logic                  BR,
  output logic                  dma_end,
  output logic                  d_readM,
  output logic                  d_writeM,
  output logic [WORD_SIZE-1:0]  d_address,
  inout  logic [FETCH_SIZE-1:0] d_data,
  output logic [WORD_SIZE-1:0]  dev_offset,
  input  logic [FETCH_SIZE-1:0] dev_data
);

  localparam int unsigned WordsPerBurst = FETCH_SIZE / WORD_SIZE;
  localparam int unsigned NumBursts     = TOTAL_WORDS / WordsPerBurst;
  localparam int unsigned BurstW        = (NumBursts > 1) ? $clog2(NumBursts) : 1;
  localparam int unsigned CntW          = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [BurstW-1:0]    LastBurst   = BurstW'(NumBursts - 1);
  localparam logic [CntW-1:0]      LastCnt     = CntW'(MEM_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] BurstStride = WORD_SIZE'(WordsPerBurst);

  dma_state_e           state_q;
  logic [BurstW-1:0]    burst_q;
  logic [CntW-1:0]      cnt_q;
  logic                 br_q;
  logic                 dma_end_q;
  logic [WORD_SIZE-1:0] dev_offset_q;

  logic                 own;
  logic [WORD_SIZE-1:0] burst_off;
  logic [WORD_SIZE-1:0] bus_addr;

  // BG is sampled combinationally so a mid-burst grant drop releases the bus at once.
  assign own       = (state_q == StXfer) && BG;
  assign burst_off = WORD_SIZE'(burst_q) * BurstStride;
  assign bus_addr  = BASE_ADDR + burst_off;  // wraps at WORD_SIZE bits

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q      <= StIdle;
      burst_q      <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      dma_end_q    <= 1'b0;
      dev_offset_q <= '0;
    end else begin
      dma_end_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd) begin
            state_q <= StReq;
            br_q    <= 1'b1;
          end
        end
        StReq: begin
          if (BG) begin
            state_q      <= StXfer;
            burst_q      <= '0;
            cnt_q        <= '0;
            dev_offset_q <= '0;
          end
        end
        StXfer: begin
          // Without BG the burst position freezes; paused cycles do not count.
          if (BG) begin
            if (cnt_q == LastCnt) begin
              if (burst_q == LastBurst) begin
                state_q <= StDone;
                br_q    <= 1'b0;
              end else begin
                burst_q      <= burst_q + BurstW'(1);
                cnt_q        <= '0;
                dev_offset_q <= burst_off + BurstStride;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          if (!BG) begin
            state_q   <= StIdle;
            dma_end_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BR         = br_q;
  assign dma_end    = dma_end_q;
  assign dev_offset = dev_offset_q;

  dma_bus_driver #(
    .WORD_SIZE (WORD_SIZE),
    .FETCH_SIZE(FETCH_SIZE)
  ) u_bus_driver (
    .own_i      (own),
    .addr_i     (bus_addr),
    .data_i     (dev_data),
    .d_read_o   (d_readM),
    .d_write_o  (d_writeM),
    .d_address_o(d_address),
    .d_data_io  (d_data)
  );

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: stimulus pushes expected write cycles into a
// queue, per-instance monitors pop and compare on every cycle the DUT writes.
module tb_dma_controller;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] off;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cmd0, bg0, cmd1, bg1;

  wire        br0, end0, rd0, wr0;
  wire [15:0] addr0, off0;
  wire [63:0] dd0, dev0;
  wire        br1, end1, rd1, wr1;
  wire [15:0] addr1, off1;
  wire [63:0] dd1, dev1;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt0 = 0, wr_cnt1 = 0, end_cnt0 = 0, end_cnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // Device model: distinct pattern per offset so wrong offsets show up in d_data.
  function automatic logic [63:0] dev_fn(input logic [15:0] off);
    return {off + 16'h3003, off + 16'h2002, off + 16'h1001, off ^ 16'hA5A5};
  endfunction

  assign dev0 = dev_fn(off0);
  assign dev1 = dev_fn(off1);

  dma_controller u_dut0 (
    .Clk(clk), .Reset_N(rst_n), .cmd(cmd0), .BG(bg0), .BR(br0), .dma_end(end0),
    .d_readM(rd0), .d_writeM(wr0), .d_address(addr0), .d_data(dd0),
    .dev_offset(off0), .dev_data(dev0)
  );

  dma_controller #(
    .BASE_ADDR  (16'hFFFC),
    .TOTAL_WORDS(8)
  ) u_dut1 (
    .Clk(clk), .Reset_N(rst_n), .cmd(cmd1), .BG(bg1), .BR(br1), .dma_end(end1),
    .d_readM(rd1), .d_writeM(wr1), .d_address(addr1), .d_data(dd1),
    .dev_offset(off1), .dev_data(dev1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_t(input string nm, input bit ok, input logic [63:0] act);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required condition not met", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write cycles: 4 cycles per burst, 4 words per burst.
  task automatic push_cycles(input int inst, input logic [15:0] base, input int ncyc);
    exp_t x;
    for (int c = 0; c < ncyc; c++) begin
      x.off  = 16'((c / 4) * 4);
      x.addr = base + x.off;
      if (inst == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (wr0 === 1'b1) begin
      wr_cnt0++;
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr0_unexpected: write at addr %h, required no write", addr0);
      end else begin
        e0 = q0.pop_front();
        chk("wr0_addr", addr0, e0.addr);
        chk("wr0_off", off0, e0.off);
        chk("wr0_data", dd0, dev_fn(e0.off));
        chk("wr0_rd", rd0, 1'b0);
      end
    end else begin
      chk_t("bus0_z", (rd0 === 1'bz) && (wr0 === 1'bz) && (addr0 === 16'hzzzz) &&
            (dd0 === 64'hzzzz_zzzz_zzzz_zzzz), {rd0, wr0, addr0});
    end
    if (end0 === 1'b1) begin
      end_cnt0++;
      chk("end0_no_br", br0, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      wr_cnt1++;
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr1_unexpected: write at addr %h, required no write", addr1);
      end else begin
        e1 = q1.pop_front();
        chk("wr1_addr", addr1, e1.addr);
        chk("wr1_off", off1, e1.off);
        chk("wr1_data", dd1, dev_fn(e1.off));
      end
    end else begin
      chk_t("bus1_z", (wr1 === 1'bz) && (addr1 === 16'hzzzz), {wr1, addr1});
    end
    if (end1 === 1'b1) begin
      end_cnt1++;
      chk("end1_no_br", br1, 1'b0);
    end
  end

  task automatic start0();
    cmd0 = 1'b1;
    tick();
    cmd0 = 1'b0;
    chk("req_br0", br0, 1'b1);
    tick();
    bg0 = 1'b1;
  endtask

  task automatic wait_wr0(input int n, input int base);
    int k = 0;
    while ((wr_cnt0 - base) < n && k < 100) begin
      tick();
      k++;
    end
    chk_t("wr0_wait", (wr_cnt0 - base) >= n, 64'(wr_cnt0 - base));
  endtask

  task automatic wait_br_low0();
    int k = 0;
    while (br0 !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    chk_t("br0_fall", br0 === 1'b0, br0);
  endtask

  task automatic finish0(input int w, input int e);
    wait_br_low0();
    chk("xfer0_words", 64'(wr_cnt0 - w), 12);
    chk("q0_empty", 64'(q0.size()), 0);
    chk("off0_hold_done", off0, 16'h0008);
    bg0 = 1'b0;
    tick();
    chk("end0_pulse", end0, 1'b1);
    tick();
    chk("end0_clear", end0, 1'b0);
    chk("end0_count", 64'(end_cnt0 - e), 1);
    chk("off0_hold_idle", off0, 16'h0008);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, e, k;
    rst_n = 1'b1;
    cmd0 = 1'b0; bg0 = 1'b0; cmd1 = 1'b0; bg1 = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_br0", br0, 1'b0);
    chk("rst_end0", end0, 1'b0);
    chk("rst_off0", off0, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_br0", br0, 1'b0);
      chk("idle_end0", end0, 1'b0);
    end

    // Plain transfer
    w = wr_cnt0; e = end_cnt0;
    push_cycles(0, 16'h01F4, 12);
    start0();
    finish0(w, e);

    // BG dropped for 3 cycles in the middle of burst 1
    repeat (2) tick();
    w = wr_cnt0; e = end_cnt0;
    push_cycles(0, 16'h01F4, 12);
    start0();
    wait_wr0(6, w);
    bg0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_t("pause_addr_z", addr0 === 16'hzzzz, addr0);
      chk("pause_off", off0, 16'h0004);
      chk("pause_br", br0, 1'b1);
      tick();
    end
    bg0 = 1'b1;
    finish0(w, e);

    // cmd during XFER and DONE is ignored
    repeat (2) tick();
    w = wr_cnt0; e = end_cnt0;
    push_cycles(0, 16'h01F4, 12);
    start0();
    wait_wr0(2, w);
    cmd0 = 1'b1;
    tick();
    tick();
    cmd0 = 1'b0;
    wait_br_low0();
    cmd0 = 1'b1;
    tick();
    cmd0 = 1'b0;
    chk("done_cmd_br0", br0, 1'b0);
    bg0 = 1'b0;
    tick();
    chk("c_end0_pulse", end0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_no_restart_br0", br0, 1'b0);
    end
    chk("c_end0_count", 64'(end_cnt0 - e), 1);
    chk("c_words", 64'(wr_cnt0 - w), 12);
    chk("c_q0_empty", 64'(q0.size()), 0);

    // Fresh transfer from IDLE starts again at the base address
    w = wr_cnt0; e = end_cnt0;
    push_cycles(0, 16'h01F4, 12);
    start0();
    finish0(w, e);

    // Reset during burst 2 aborts without dma_end
    repeat (2) tick();
    w = wr_cnt0; e = end_cnt0;
    push_cycles(0, 16'h01F4, 9);
    start0();
    wait_wr0(9, w);
    rst_n = 1'b0;
    bg0 = 1'b0;
    #1;
    chk("arst_br0", br0, 1'b0);
    chk("arst_end0", end0, 1'b0);
    chk_t("arst_bus_z", (wr0 === 1'bz) && (addr0 === 16'hzzzz), {wr0, addr0});
    chk("arst_off0", off0, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arst_quiet_br0", br0, 1'b0);
    end
    chk("arst_no_end", 64'(end_cnt0 - e), 0);
    chk("arst_words", 64'(wr_cnt0 - w), 9);
    chk("arst_q0_empty", 64'(q0.size()), 0);
    w = wr_cnt0; e = end_cnt0;
    push_cycles(0, 16'h01F4, 12);
    start0();
    finish0(w, e);

    // Second instance: BASE_ADDR=FFFC, 8 words, address wraps to 0000
    w = wr_cnt1; e = end_cnt1;
    push_cycles(1, 16'hFFFC, 8);
    cmd1 = 1'b1;
    tick();
    cmd1 = 1'b0;
    chk("req_br1", br1, 1'b1);
    tick();
    bg1 = 1'b1;
    k = 0;
    while (br1 !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    chk_t("br1_fall", br1 === 1'b0, br1);
    chk("xfer1_words", 64'(wr_cnt1 - w), 8);
    chk("q1_empty", 64'(q1.size()), 0);
    bg1 = 1'b0;
    tick();
    chk("end1_pulse", end1, 1'b1);
    tick();
    chk("end1_clear", end1, 1'b0);
    chk("end1_count", 64'(end_cnt1 - e), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
